queue_input_ctrl: RTL

QUEUE_INPUT_CTRL -- requirements
Module: queue_input_ctrl

---
 rtl/queue_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 120 ++++++++++++
 rtl/queue_input_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared defaults and debouncer state encoding for the queue input controller.
// Optional autorepeat is enabled with QUEUE_INPUT_CTRL_AUTOREPEAT_EN.
package queue_pkg;

   localparam int QW_DEF         = 4;
   localparam int DB_CYCLES_DEF  = 500000;
   localparam int REP_DELAY_DEF  = 50000000;
   localparam int REP_PERIOD_DEF = 10000000;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_e;

   // Width of a counter that must reach n without wrapping.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer + debounce FSM; one-cycle evt per press, plus held repeats under QUEUE_INPUT_CTRL_AUTOREPEAT_EN.
// Latency: evt rises DB_CYCLES+2 cycles after the first edge sampling btn high; no backpressure.
module btn_debounce
   import queue_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef QUEUE_INPUT_CTRL_AUTOREPEAT_EN
   ,
   parameter int REP_DELAY  = REP_DELAY_DEF,
   parameter int REP_PERIOD = REP_PERIOD_DEF
`endif
) (
   input  logic clk100,
   input  logic rst,
   input  logic btn,
   output logic evt
);

   localparam int            CW     = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

   logic          sync1;
   logic          sync2;
   db_state_e     state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          press_done;
   logic          rep_fire;

   // Saturating increment: the counter never wraps past DB_MAX.
   assign cnt_inc    = (cnt == DB_MAX) ? cnt : cnt + CW'(1);
   assign press_done = (state == PRESS_WAIT) && sync2 && (cnt_inc == DB_MAX);

`ifdef QUEUE_INPUT_CTRL_AUTOREPEAT_EN
   localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int RW   = cnt_width(RMAX);

   logic [RW-1:0] rep_cnt;
   logic [RW-1:0] rep_inc;
   logic [RW-1:0] rep_lim;
   logic          rep_first;

   assign rep_inc  = rep_cnt + RW'(1);
   assign rep_lim  = rep_first ? RW'(REP_DELAY) : RW'(REP_PERIOD);
   assign rep_fire = (state == HELD) && sync2 && (rep_inc == rep_lim);

   // Timer only advances while HELD, so RELEASE_WAIT pauses it in place.
   always_ff @(posedge clk100) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else if (press_done) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if ((state == HELD) && sync2) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_inc;
         end
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_ff @(posedge clk100) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         evt   <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         evt   <= rep_fire;
         case (state)
            IDLE: begin
               if (sync2) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (press_done) begin
                  state <= HELD;
                  cnt   <= '0;
                  evt   <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            HELD: begin
               if (!sync2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (sync2) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt_inc == DB_MAX) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/queue_input_ctrl.sv
// Turns push/pop buttons and data switches into one-cycle queue strobes; autorepeat via QUEUE_INPUT_CTRL_AUTOREPEAT_EN.
// Latency: strobe DB_CYCLES+3 cycles after press; full/empty drop commands with a reject pulse.
module queue_input_ctrl
   import queue_pkg::*;
#(
   parameter int QW         = QW_DEF,
   parameter int DB_CYCLES  = DB_CYCLES_DEF,
   parameter int REP_DELAY  = REP_DELAY_DEF,
   parameter int REP_PERIOD = REP_PERIOD_DEF
) (
   input  logic          clk100,
   input  logic          rst,
   input  logic          btn_in,
   input  logic          btn_out,
   input  logic [QW-1:0] sw,
   input  logic          full,
   input  logic          empty,
   output logic          push,
   output logic          pop,
   output logic [QW-1:0] push_data,
   output logic          reject
);

   logic          push_evt;
   logic          pop_evt;
   logic          pop_pend;
   logic          pop_req;
   logic [QW-1:0] sw_s1;
   logic [QW-1:0] sw_s2;

`ifdef QUEUE_INPUT_CTRL_AUTOREPEAT_EN
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_db_in (
      .clk100(clk100), .rst(rst), .btn(btn_in), .evt(push_evt)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)) u_db_out (
      .clk100(clk100), .rst(rst), .btn(btn_out), .evt(pop_evt)
   );
`else
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_in (
      .clk100(clk100), .rst(rst), .btn(btn_in), .evt(push_evt)
   );
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_out (
      .clk100(clk100), .rst(rst), .btn(btn_out), .evt(pop_evt)
   );
`endif

   assign pop_req = pop_evt | pop_pend;

   // Push wins a collision; the pop waits one cycle and is re-checked against empty then.
   always_ff @(posedge clk100) begin
      if (rst) begin
         sw_s1     <= '0;
         sw_s2     <= '0;
         push      <= 1'b0;
         pop       <= 1'b0;
         reject    <= 1'b0;
         push_data <= '0;
         pop_pend  <= 1'b0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         push   <= 1'b0;
         pop    <= 1'b0;
         reject <= 1'b0;
         if (push_evt) begin
            pop_pend <= pop_req;
            if (full) begin
               reject <= 1'b1;
            end else begin
               push      <= 1'b1;
               push_data <= sw_s2;
            end
         end else begin
            pop_pend <= 1'b0;
            if (pop_req) begin
               if (empty) reject <= 1'b1;
               else       pop    <= 1'b1;
            end
         end
      end
   end

endmodule
